prog_clk_div: RTL and testbench

Programmable integer clock divider with runtime-selectable divide ratio and duty cycle. It replaces the fixed divide-by-two toggle in the mixed-signal clock tree. It generates an enable-style divided clock plus a period-start strobe for downstream samplers and DAC/ADC sequencers. Configuration changes and start/stop are glitch-free: they take effect only at output-period boundaries.

---
 rtl/clkdiv_pkg.sv | 21 ++
 rtl/clkdiv_phase_counter.sv | 75 +++++++
 rtl/prog_clk_div.sv | 103 ++++++++++
 tb/tb_prog_clk_div.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and configuration checks for the programmable clock divider.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned CFG_W = 32;

  // A divisor/high-time pair is usable when the period has at least one high and one low cycle.
  function automatic logic cfg_legal(input logic [CFG_W-1:0] div, input logic [CFG_W-1:0] high);
    return (div >= 32'd2) && (high >= 32'd1) && (high < div);
  endfunction

  function automatic logic defaults_ok(input int cnt_w, input int div, input int high);
    return (div >= 32'sd2) && (high >= 32'sd1) && (high < div) && (div < (32'sd1 <<< cnt_w));
  endfunction

endpackage

// File: rtl/clkdiv_phase_counter.sv
// Phase counter of the divider: active N/H registers, cycle counter and registered clk_out/tick.
module clkdiv_phase_counter #(
  parameter int CNT_W    = 8,
  parameter int DEF_DIV  = 2,
  parameter int DEF_HIGH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             idle,
  input  logic             go_idle,
  input  logic             load,
  input  logic [CNT_W-1:0] new_div,
  input  logic [CNT_W-1:0] new_high,
  output logic             at_end,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_HI_C  = CNT_W'(DEF_HIGH);

  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] act_high;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt;
  logic [CNT_W-1:0] eff_div;
  logic [CNT_W-1:0] eff_high;

  assign at_end = (cnt == (act_div - ONE));

  // A config loaded on this edge already governs the period that starts on it.
  always_comb begin
    eff_div  = act_div;
    eff_high = act_high;
    nxt      = cnt + ONE;
    if (load) begin
      eff_div  = new_div;
      eff_high = new_high;
    end else begin
      eff_div  = act_div;
      eff_high = act_high;
    end
    if (idle || at_end) begin
      nxt = {CNT_W{1'b0}};
    end else begin
      nxt = cnt + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act_div  <= DEF_DIV_C;
      act_high <= DEF_HI_C;
      cnt      <= DEF_DIV_C - ONE;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (load) begin
        act_div  <= new_div;
        act_high <= new_high;
      end
      if (go_idle) begin
        cnt     <= eff_div - ONE;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else begin
        cnt     <= nxt;
        clk_out <= (nxt < eff_high);
        tick    <= (nxt == {CNT_W{1'b0}});
      end
    end
  end

endmodule

// File: rtl/prog_clk_div.sv
// Programmable integer clock divider: run/drain FSM plus a one-deep configuration slot applied at period boundaries.
module prog_clk_div
  import clkdiv_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEF_DIV  = 2,
  parameter int DEF_HIGH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_err,
  output logic             busy
);

  if (!defaults_ok(CNT_W, DEF_DIV, DEF_HIGH)) begin : g_bad_defaults
    $error("prog_clk_div: DEF_DIV/DEF_HIGH out of range");
  end

  state_t           state;
  state_t           state_nxt;
  logic             pend_full;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] pend_high;
  logic             at_end;
  logic             idle;
  logic             accept;
  logic             legal;
  logic             apply;
  logic             go_idle;

  assign idle      = (state == ST_IDLE);
  assign cfg_ready = !pend_full;
  assign accept    = cfg_valid && !pend_full;
  assign legal     = cfg_legal(CFG_W'(cfg_div), CFG_W'(cfg_high));
  // Every edge out of IDLE and every period end is a safe point to swap the divisor.
  assign apply     = pend_full && (idle || at_end);
  assign go_idle   = (state_nxt == ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_RUN;
        else    state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (en)          state_nxt = ST_RUN;
        else if (at_end) state_nxt = ST_IDLE;
        else             state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (at_end) state_nxt = ST_IDLE;
        else        state_nxt = ST_DRAIN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      pend_full <= 1'b0;
      pend_div  <= {CNT_W{1'b0}};
      pend_high <= {CNT_W{1'b0}};
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != ST_IDLE);
      cfg_err   <= accept && !legal;
      pend_full <= (pend_full && !apply) || (accept && legal);
      if (accept && legal) begin
        pend_div  <= cfg_div;
        pend_high <= cfg_high;
      end
    end
  end

  clkdiv_phase_counter #(
    .CNT_W    (CNT_W),
    .DEF_DIV  (DEF_DIV),
    .DEF_HIGH (DEF_HIGH)
  ) u_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .idle     (idle),
    .go_idle  (go_idle),
    .load     (apply),
    .new_div  (pend_div),
    .new_high (pend_high),
    .at_end   (at_end),
    .clk_out  (clk_out),
    .tick     (tick)
  );

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed cycle-by-cycle bench for prog_clk_div with default parameters (N=2, H=1).
module tb_prog_clk_div;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic [7:0] cfg_high = 8'd0;
  logic       cfg_ready;
  logic       clk_out;
  logic       tick;
  logic       cfg_err;
  logic       busy;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       vld;
    logic [7:0] div;
    logic [7:0] high;
    logic       e_clk;
    logic       e_tick;
    logic       e_err;
    logic       e_busy;
    logic       e_rdy;
  } vec_t;

  vec_t tbl [20];

  prog_clk_div dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .clk_out   (clk_out),
    .tick      (tick),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let one edge pass, then compare the five outputs.
  task automatic v(input logic r, input logic e, input logic vl, input logic [7:0] d,
                   input logic [7:0] h, input logic ec, input logic et, input logic ee,
                   input logic eb, input logic er, input string nm);
    logic [4:0] got;
    logic [4:0] exp;
    reset_n   = r;
    en        = e;
    cfg_valid = vl;
    cfg_div   = d;
    cfg_high  = h;
    @(posedge clk);
    #1;
    got = {clk_out, tick, cfg_err, busy, cfg_ready};
    exp = {ec, et, ee, eb, er};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: clk_out/tick/cfg_err/busy/cfg_ready got %b expected %b", nm, got, exp);
    end
  endtask

  initial begin
    // Defaults, mid-run reconfiguration to N=5/H=2, then two illegal offers.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'd5, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 8'd5, 8'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 8'd1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 20; i++) begin
      v(tbl[i].rst_n, tbl[i].en, tbl[i].vld, tbl[i].div, tbl[i].high,
        tbl[i].e_clk, tbl[i].e_tick, tbl[i].e_err, tbl[i].e_busy, tbl[i].e_rdy,
        $sformatf("tbl[%0d]", i));
    end

    // N=6/H=3 loaded in IDLE, en dropped at cnt=1, drain, restart, then stop at a boundary.
    v(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "drn_reset");
    v(1'b1, 1'b0, 1'b1, 8'd6, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "drn_accept_idle");
    v(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "drn_apply_idle");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "drn_start");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "drn_cnt1");
    v(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "drn_cnt2");
    v(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "drn_cnt3");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "drn_en_ignored");
    v(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "drn_cnt5");
    v(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "drn_to_idle");
    v(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "drn_idle_hold");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "drn_restart");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "rst_n6_c1");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "rst_n6_c2");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "rst_n6_c3");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "rst_n6_c4");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "rst_n6_c5");
    v(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "run_to_idle_boundary");

    // Back-to-back configs with cfg_valid held: period 4 (H=1), then period 3 (H=2).
    v(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_reset");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "b2b_start");
    v(1'b1, 1'b1, 1'b1, 8'd4, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_accept1");
    v(1'b1, 1'b1, 1'b1, 8'd3, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "b2b_apply1");
    v(1'b1, 1'b1, 1'b1, 8'd3, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_accept2");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_n4_c2");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_n4_c3");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "b2b_apply2");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "b2b_n3_c1");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "b2b_n3_c2");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "b2b_n3_wrap");

    // Reset in the high phase with N=7/H=3 pending: defaults must come back, pending lost.
    v(1'b1, 1'b1, 1'b1, 8'd7, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "mid_pend_accept");
    v(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mid_reset");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "post_rst_c0");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "post_rst_c1");
    v(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "post_rst_c2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
